// File: rtl/water_level_decoder.sv
// Glitch-filtered water level register with one-hot, 7-segment, supply and blinking-alarm decodes.
// Optional trend pulses (level_rising/level_falling) are built only when WATER_TREND_EN is defined.
module water_level_decoder #(
    parameter int STABLE_CYCLES     = 4,
    parameter int BLINK_HALF_PERIOD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] encoded_water,
    output logic [1:0] level,
    output logic       critical_level,
    output logic       low_level,
    output logic       mid_level,
    output logic       high_level,
    output logic       level_changed,
    output logic       alarm,
    output logic       water_supply_enable,
    output logic [6:0] segments,
    output logic       level_rising,
    output logic       level_falling
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } alarm_state_t;

    logic [1:0]    candidate;
    logic [SW-1:0] stable_count;
    logic [SW-1:0] stable_count_d;
    logic          accept;
    logic [1:0]    level_d;

    alarm_state_t  alarm_state;
    alarm_state_t  alarm_state_d;
    logic [BW-1:0] blink_count;
    logic [BW-1:0] blink_count_d;
    logic          blink_phase;
    logic          blink_phase_d;

    // The edge that first sees a new code already counts as sample one of the run.
    always_comb begin
        stable_count_d = stable_count;
        if (encoded_water != candidate) begin
            stable_count_d = SW'(1);
        end else if (stable_count != STABLE_MAX) begin
            stable_count_d = stable_count + SW'(1);
        end
    end

    assign accept  = (stable_count_d == STABLE_MAX) && (encoded_water != level);
    assign level_d = accept ? encoded_water : level;

    always_ff @(posedge clock) begin
        if (reset) begin
            candidate     <= 2'b00;
            stable_count  <= '0;
            level         <= 2'b00;
            level_changed <= 1'b0;
        end else begin
            candidate     <= encoded_water;
            stable_count  <= stable_count_d;
            level         <= level_d;
            level_changed <= accept;
        end
    end

`ifdef WATER_TREND_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            level_rising  <= 1'b0;
            level_falling <= 1'b0;
        end else begin
            level_rising  <= accept && (encoded_water > level);
            level_falling <= accept && (encoded_water < level);
        end
    end
`else
    assign level_rising  = 1'b0;
    assign level_falling = 1'b0;
`endif

    // Alarm FSM follows the level being loaded so it switches on the same edge as the level register.
    always_ff @(posedge clock) begin
        if (reset) begin
            alarm_state <= BLINK;
            blink_count <= '0;
            blink_phase <= 1'b1;
        end else begin
            alarm_state <= alarm_state_d;
            blink_count <= blink_count_d;
            blink_phase <= blink_phase_d;
        end
    end

    always_comb begin
        alarm_state_d = alarm_state;
        blink_count_d = blink_count;
        blink_phase_d = blink_phase;
        case (alarm_state)
            IDLE: begin
                blink_count_d = '0;
                blink_phase_d = 1'b0;
                if (level_d == 2'b00) begin
                    alarm_state_d = BLINK;
                    blink_phase_d = 1'b1;
                end
            end
            BLINK: begin
                if (level_d != 2'b00) begin
                    alarm_state_d = IDLE;
                    blink_count_d = '0;
                    blink_phase_d = 1'b0;
                end else if (blink_count == BLINK_LAST) begin
                    blink_count_d = '0;
                    blink_phase_d = ~blink_phase;
                end else begin
                    blink_count_d = blink_count + BW'(1);
                end
            end
            default: begin
                alarm_state_d = IDLE;
                blink_count_d = '0;
                blink_phase_d = 1'b0;
            end
        endcase
    end

    assign alarm = (alarm_state == BLINK) && blink_phase;

    always_comb begin
        critical_level      = (level == 2'b00);
        low_level           = (level == 2'b01);
        mid_level           = (level == 2'b10);
        high_level          = (level == 2'b11);
        water_supply_enable = (level != 2'b00);
        case (level)
            2'b00:   segments = 7'b1000000;
            2'b01:   segments = 7'b1111001;
            2'b10:   segments = 7'b0100100;
            default: segments = 7'b0110000;
        endcase
    end

endmodule

// File: tb/tb_water_level_decoder.sv
// Randomized bench for water_level_decoder: two instances (filter 4/blink 8 and filter 1/blink 3)
// compared every cycle against a run-length / elapsed-time reference model.
module tb_water_level_decoder;

    logic       clock;
    logic       reset;
    logic [1:0] encoded_water;

    logic [1:0] level0, level1;
    logic       crit0, low0, mid0, high0, chg0, alarm0, sup0, rise0, fall0;
    logic       crit1, low1, mid1, high1, chg1, alarm1, sup1, rise1, fall1;
    logic [6:0] seg0, seg1;

    water_level_decoder #(.STABLE_CYCLES(4), .BLINK_HALF_PERIOD(8)) dut (
        .clock(clock), .reset(reset), .encoded_water(encoded_water),
        .level(level0), .critical_level(crit0), .low_level(low0), .mid_level(mid0),
        .high_level(high0), .level_changed(chg0), .alarm(alarm0),
        .water_supply_enable(sup0), .segments(seg0),
        .level_rising(rise0), .level_falling(fall0)
    );

    water_level_decoder #(.STABLE_CYCLES(1), .BLINK_HALF_PERIOD(3)) dut_fast (
        .clock(clock), .reset(reset), .encoded_water(encoded_water),
        .level(level1), .critical_level(crit1), .low_level(low1), .mid_level(mid1),
        .high_level(high1), .level_changed(chg1), .alarm(alarm1),
        .water_supply_enable(sup1), .segments(seg1),
        .level_rising(rise1), .level_falling(fall1)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard
    int n_pass  = 0;
    int n_total = 0;

    int m_stab[2] = '{4, 1};
    int m_half[2] = '{8, 3};
    int m_level[2];
    int m_code[2];
    int m_len[2];
    int m_age[2];
    bit m_chg[2];
    bit m_rise[2];
    bit m_fall[2];
    logic [6:0] seg_tbl[4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        if (observed === expected) n_pass++;
        else $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic model_step(input int id, input int s, input bit r);
        int prev;
        if (r) begin
            m_level[id] = 0; m_code[id] = 0; m_len[id] = 0; m_age[id] = 0;
            m_chg[id] = 0; m_rise[id] = 0; m_fall[id] = 0;
            return;
        end
        prev = m_level[id];
        if (s == m_code[id]) m_len[id]++;
        else begin
            m_code[id] = s;
            m_len[id]  = 1;
        end
        m_chg[id] = 0; m_rise[id] = 0; m_fall[id] = 0;
        if (m_len[id] >= m_stab[id] && s != m_level[id]) begin
            m_level[id] = s;
            m_chg[id]   = 1;
            m_rise[id]  = (s > prev);
            m_fall[id]  = (s < prev);
        end
        if (m_level[id] == 0) m_age[id] = (prev != 0) ? 0 : m_age[id] + 1;
    endtask

    task automatic compare_outputs(input int id, input logic [1:0] lv, input logic crit, input logic low,
                                   input logic mid, input logic high, input logic chg, input logic alm,
                                   input logic sup, input logic [6:0] seg, input logic rise, input logic fall);
        bit exp_alarm;
        bit exp_rise;
        bit exp_fall;
        exp_alarm = (m_level[id] == 0) && (((m_age[id] / m_half[id]) % 2) == 0);
`ifdef WATER_TREND_EN
        exp_rise = m_rise[id];
        exp_fall = m_fall[id];
`else
        exp_rise = 1'b0;
        exp_fall = 1'b0;
`endif
        check($sformatf("d%0d.level", id),    32'(lv),   32'(m_level[id]));
        check($sformatf("d%0d.critical", id), 32'(crit), 32'(m_level[id] == 0));
        check($sformatf("d%0d.low", id),      32'(low),  32'(m_level[id] == 1));
        check($sformatf("d%0d.mid", id),      32'(mid),  32'(m_level[id] == 2));
        check($sformatf("d%0d.high", id),     32'(high), 32'(m_level[id] == 3));
        check($sformatf("d%0d.changed", id),  32'(chg),  32'(m_chg[id]));
        check($sformatf("d%0d.alarm", id),    32'(alm),  32'(exp_alarm));
        check($sformatf("d%0d.supply", id),   32'(sup),  32'(m_level[id] != 0));
        check($sformatf("d%0d.segments", id), 32'(seg),  32'(seg_tbl[m_level[id]]));
        check($sformatf("d%0d.rising", id),   32'(rise), 32'(exp_rise));
        check($sformatf("d%0d.falling", id),  32'(fall), 32'(exp_fall));
    endtask

    // driver: apply one sample (and reset) for one edge, then check both instances
    task automatic drive_cycle(input logic [1:0] s, input bit r);
        encoded_water = s;
        reset = r;
        @(posedge clock);
        #1;
        model_step(0, int'(s), r);
        model_step(1, int'(s), r);
        compare_outputs(0, level0, crit0, low0, mid0, high0, chg0, alarm0, sup0, seg0, rise0, fall0);
        compare_outputs(1, level1, crit1, low1, mid1, high1, chg1, alarm1, sup1, seg1, rise1, fall1);
    endtask

    task automatic drive_run(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) drive_cycle(s, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        encoded_water = 2'b00;
        drive_cycle(2'b00, 1'b1);
        drive_cycle(2'b00, 1'b1);
        check("reset.segments", 32'(seg0), 32'(7'b1000000));
        check("reset.alarm", 32'(alarm0), 32'd1);

        // critical hold: two full blink periods
        drive_run(2'b00, 34);
        // short run that falls back to the current level
        drive_run(2'b01, 3);
        drive_run(2'b00, 2);
        // accepted mid level
        drive_run(2'b10, 4);
        check("dir.mid_level", 32'(level0), 32'd2);
        drive_run(2'b10, 2);
        // interrupted run then a falling step, then a rising step
        drive_run(2'b11, 2);
        drive_run(2'b01, 4);
        check("dir.low_level", 32'(level0), 32'd1);
        drive_run(2'b11, 5);
        // reset mid-filter
        drive_run(2'b01, 4);
        drive_run(2'b11, 3);
        drive_cycle(2'b11, 1'b1);
        check("dir.reset_mid_filter", 32'(level0), 32'd0);
        drive_run(2'b11, 2);
        // reset mid-blink
        drive_run(2'b00, 6);
        drive_run(2'b00, 11);
        drive_cycle(2'b00, 1'b1);
        check("dir.reset_mid_blink", 32'(alarm0), 32'd1);
        drive_run(2'b00, 12);

        // randomized runs of varying length with occasional resets
        for (int k = 0; k < 400; k++) begin
            logic [1:0] code;
            code = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) drive_cycle(code, 1'b1);
            else drive_run(code, int'($urandom_range(1, 6)));
            if ($urandom_range(0, 9) == 0) drive_run(2'b00, int'($urandom_range(5, 20)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
